// File: rtl/trama_pkg.sv
// trama_pkg: shared state encoding, frame layout and range limits for the trama receiver.
package trama_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT, S_ERROR} state_t;
    localparam logic [7:0] SOF = 8'hAA;
    localparam int N_PAYLOAD = 9;
    localparam logic [3:0] IDX_HUM_H = 4'd0;
    localparam logic [3:0] IDX_HUM_L = 4'd1;
    localparam logic [3:0] IDX_MEL   = 4'd2;
    localparam logic [3:0] IDX_POT   = 4'd3;
    localparam logic [3:0] IDX_HORA  = 4'd4;
    localparam logic [3:0] IDX_MIN   = 4'd5;
    localparam logic [3:0] IDX_LUX_H = 4'd6;
    localparam logic [3:0] IDX_LUX_M = 4'd7;
    localparam logic [3:0] IDX_LUX_L = 4'd8;
    localparam logic [3:0] IDX_LAST  = 4'(N_PAYLOAD - 1);
    localparam logic [7:0] HORA_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m);
        return (h <= HORA_MAX) && (m <= MIN_MAX);
    endfunction
endpackage

// File: rtl/trama_timeout.sv
// trama_timeout: inter-byte gap counter; counts while enabled, clears on i_clr, flags and holds at TIMEOUT.
module trama_timeout #(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);
    localparam int unsigned W = $clog2(TIMEOUT + 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clr || !i_en) r_cnt <= '0;
        else if (!o_expired) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expired = r_cnt == W'(TIMEOUT);
endmodule

// File: rtl/trama_rx.sv
// trama_rx: validates SOF/payload/CHK frames from the ESP8266 and publishes the decoded fields
// atomically, one clk after a good checksum byte.
module trama_rx
    import trama_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    input  logic        rx_err,
    output logic [11:0] humedad,
    output logic [3:0]  melodia1,
    output logic [3:0]  melodia2,
    output logic [3:0]  maceta,
    output logic [3:0]  tipoPlanta,
    output logic [7:0]  hora,
    output logic [7:0]  minutos,
    output logic [19:0] luxes,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);
    state_t r_state, w_next;
    logic w_byte, w_live, w_exp, w_good;
    logic [3:0] r_idx;
    logic [7:0] r_xor;
    logic [11:0] r_s_hum, r_hum;
    logic [7:0] r_s_mel, r_s_pot, r_s_hora, r_s_min, r_mel, r_pot, r_hora, r_min, r_err_cnt;
    logic [19:0] r_s_lux, r_lux;

    // rx_err wins over a simultaneous byte strobe
    assign w_byte = byte_vld && !rx_err;
    assign w_live = (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    assign w_good = (byte_in == r_xor) && time_ok(r_s_hora, r_s_min);

    trama_timeout #(.TIMEOUT(TIMEOUT)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_live),
        .i_clr    (byte_vld),
        .o_expired(w_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:    w_next = (w_byte && byte_in == SOF) ? S_PAYLOAD : S_IDLE;
            S_PAYLOAD: w_next = (rx_err || w_exp) ? S_ERROR : (w_byte && r_idx == IDX_LAST) ? S_CHECK : S_PAYLOAD;
            S_CHECK:   w_next = (rx_err || w_exp || (w_byte && !w_good)) ? S_ERROR : w_byte ? S_COMMIT : S_CHECK;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        frame_ok  = r_state == S_COMMIT;
        frame_err = r_state == S_ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_xor    <= '0;
            r_s_hum  <= '0;
            r_s_mel  <= '0;
            r_s_pot  <= '0;
            r_s_hora <= '0;
            r_s_min  <= '0;
            r_s_lux  <= '0;
        end else if (r_state == S_IDLE) begin
            r_idx <= '0;
            r_xor <= '0;
        end else if (r_state == S_PAYLOAD && w_byte) begin
            r_idx <= r_idx + 1'b1;
            r_xor <= r_xor ^ byte_in;
            case (r_idx)
                IDX_HUM_H: r_s_hum[11:8]  <= byte_in[3:0];
                IDX_HUM_L: r_s_hum[7:0]   <= byte_in;
                IDX_MEL:   r_s_mel        <= byte_in;
                IDX_POT:   r_s_pot        <= byte_in;
                IDX_HORA:  r_s_hora       <= byte_in;
                IDX_MIN:   r_s_min        <= byte_in;
                IDX_LUX_H: r_s_lux[19:16] <= byte_in[3:0];
                IDX_LUX_M: r_s_lux[15:8]  <= byte_in;
                IDX_LUX_L: r_s_lux[7:0]   <= byte_in;
                default:   ;
            endcase
        end
    end

    // Fields load on the CHK strobe edge so they appear together with frame_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hum  <= '0;
            r_mel  <= '0;
            r_pot  <= '0;
            r_hora <= '0;
            r_min  <= '0;
            r_lux  <= '0;
        end else if (r_state == S_CHECK && w_next == S_COMMIT) begin
            r_hum  <= r_s_hum;
            r_mel  <= r_s_mel;
            r_pot  <= r_s_pot;
            r_hora <= r_s_hora;
            r_min  <= r_s_min;
            r_lux  <= r_s_lux;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err_cnt <= '0;
        else if (w_next == S_ERROR && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign humedad    = r_hum;
    assign melodia1   = r_mel[7:4];
    assign melodia2   = r_mel[3:0];
    assign maceta     = r_pot[7:4];
    assign tipoPlanta = r_pot[3:0];
    assign hora       = r_hora;
    assign minutos    = r_min;
    assign luxes      = r_lux;
    assign err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_trama_rx.sv
// tb_trama_rx: table-driven frame vectors plus directed sequences for noise, rx_err, timeout,
// reset and error-counter saturation.
module tb_trama_rx;
    localparam int T = 40;

    logic clk = 0, rst = 1, byte_vld = 0, rx_err = 0;
    logic [7:0] byte_in = '0;
    logic [11:0] humedad;
    logic [3:0] melodia1, melodia2, maceta, tipoPlanta;
    logic [7:0] hora, minutos, err_cnt;
    logic [19:0] luxes;
    logic frame_ok, frame_err;

    trama_rx #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .rx_err(rx_err),
        .humedad(humedad), .melodia1(melodia1), .melodia2(melodia2), .maceta(maceta),
        .tipoPlanta(tipoPlanta), .hora(hora), .minutos(minutos), .luxes(luxes),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] hum;
        logic [3:0]  m1, m2, pot, tp;
        logic [7:0]  hora, mins;
        logic [19:0] lux;
    } fld_t;
    typedef struct {
        logic [71:0] pay;
        logic [7:0]  flip;
        logic        ok;
        fld_t        f;
    } vec_t;

    int checks = 0, errors = 0;
    fld_t exp_f, zero_f;
    int exp_err = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_fields(input string tag);
        check({tag, " humedad"}, 32'(humedad), 32'(exp_f.hum));
        check({tag, " melodia1"}, 32'(melodia1), 32'(exp_f.m1));
        check({tag, " melodia2"}, 32'(melodia2), 32'(exp_f.m2));
        check({tag, " maceta"}, 32'(maceta), 32'(exp_f.pot));
        check({tag, " tipoPlanta"}, 32'(tipoPlanta), 32'(exp_f.tp));
        check({tag, " hora"}, 32'(hora), 32'(exp_f.hora));
        check({tag, " minutos"}, 32'(minutos), 32'(exp_f.mins));
        check({tag, " luxes"}, 32'(luxes), 32'(exp_f.lux));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic bump_err();
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in = b;
        byte_vld = 1;
        @(negedge clk);
        byte_vld = 0;
    endtask

    task automatic send_frame(input string tag, input logic [71:0] pay, input logic [7:0] flip);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        send(8'hAA);
        for (int i = 0; i < 9; i++) begin
            b = pay[71-8*i -: 8];
            x ^= b;
            send(b);
        end
        check({tag, " shadow hidden"}, 32'(humedad), 32'(exp_f.hum));
        send(x ^ flip);
    endtask

    task automatic end_frame(input string tag, input logic ok, input fld_t f);
        check({tag, " frame_ok"}, 32'(frame_ok), 32'(ok));
        check({tag, " frame_err"}, 32'(frame_err), 32'(!ok));
        if (ok) exp_f = f;
        else bump_err();
        check_fields(tag);
        @(negedge clk);
        check({tag, " pulse end"}, {30'b0, frame_ok, frame_err}, 32'd0);
    endtask

    initial begin
        zero_f = '{12'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h0, 8'h0, 20'h0};
        exp_f = zero_f;
        vecs[0] = '{72'h03E821340E1E00C350, 8'h00, 1'b1, '{12'h3E8, 4'h2, 4'h1, 4'h3, 4'h4, 8'd14, 8'd30, 20'h0C350}};
        vecs[1] = '{72'h03E821340E1E00C350, 8'h01, 1'b0, zero_f};
        vecs[2] = '{72'h03E8213418_1E00C350, 8'h00, 1'b0, zero_f};
        vecs[3] = '{72'h03E821340E3C00C350, 8'h00, 1'b0, zero_f};
        vecs[4] = '{72'hF5AA7C9B173BF1AA55, 8'h00, 1'b1, '{12'h5AA, 4'h7, 4'hC, 4'h9, 4'hB, 8'd23, 8'd59, 20'h1AA55}};
        vecs[5] = '{72'h000000000000000000, 8'h00, 1'b1, zero_f};
        vecs[6] = '{72'h0FFFFFFF00000FFFFF, 8'h00, 1'b1, '{12'hFFF, 4'hF, 4'hF, 4'hF, 4'hF, 8'd0, 8'd0, 20'hFFFFF}};

        repeat (3) @(negedge clk);
        rst = 0;
        check("reset frame_ok", 32'(frame_ok), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check_fields("reset");

        for (int v = 0; v < 7; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].pay, vecs[v].flip);
            end_frame($sformatf("vec%0d", v), vecs[v].ok, vecs[v].f);
        end

        // rx_err while idle must be ignored
        @(negedge clk);
        rx_err = 1;
        @(negedge clk);
        rx_err = 0;
        check("idle rx_err frame_err", 32'(frame_err), 32'd0);
        check("idle rx_err err_cnt", 32'(err_cnt), 32'(exp_err));

        // rx_err together with byte P5
        send(8'hAA);
        for (int i = 0; i < 5; i++) send(8'h11);
        @(negedge clk);
        byte_in = 8'h1E;
        byte_vld = 1;
        rx_err = 1;
        @(negedge clk);
        byte_vld = 0;
        rx_err = 0;
        check("rx_err frame_err", 32'(frame_err), 32'd1);
        bump_err();
        check_fields("rx_err");

        begin
            int cyc;
            send(8'hAA);
            for (int i = 0; i < 4; i++) send(8'h22);
            cyc = 0;
            while (!frame_err && cyc < T + 10) begin
                @(negedge clk);
                cyc++;
            end
            check("timeout latency", 32'(cyc), 32'(T + 1));
            bump_err();
            check_fields("timeout");
        end
        send_frame("after timeout", vecs[0].pay, 8'h00);
        end_frame("after timeout", 1'b1, vecs[0].f);

        send(8'h00);
        send(8'h55);
        send(8'hFF);
        check("noise frame_err", 32'(frame_err), 32'd0);
        send_frame("noise", vecs[4].pay, 8'h00);
        end_frame("noise", 1'b1, vecs[4].f);

        begin
            int seen;
            send(8'hAA);
            for (int i = 0; i < 3; i++) send(8'h33);
            @(negedge clk);
            rst = 1;
            #1;
            exp_f = zero_f;
            exp_err = 0;
            check_fields("mid reset");
            check("mid reset pulses", {30'b0, frame_ok, frame_err}, 32'd0);
            @(negedge clk);
            rst = 0;
            seen = 0;
            repeat (T + 5) begin
                @(negedge clk);
                if (frame_err || frame_ok) seen++;
            end
            check("post reset idle pulses", 32'(seen), 32'd0);
        end
        send_frame("post reset", vecs[0].pay, 8'h00);
        end_frame("post reset", 1'b1, vecs[0].f);

        for (int i = 1; i <= 260; i++) begin
            send(8'hAA);
            @(negedge clk);
            rx_err = 1;
            @(negedge clk);
            rx_err = 0;
            bump_err();
            @(negedge clk);
            if (i == 254 || i == 255 || i == 256 || i == 260)
                check($sformatf("sat err_cnt after %0d", i), 32'(err_cnt), 32'(exp_err));
        end
        check_fields("saturated");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/trama_rx.md
Name: trama_rx

Overview:
- Frame validator between the UART receiver and the field decoder.
- Collects bytes from the serial receive path into a fixed-length frame from the ESP8266 and checks the start marker, checksum, byte-gap timeout and field ranges.
- Publishes humidity, melody, pot, plant type, time and lux fields atomically, and only for good frames.
- Downstream alarm, pump and lamp logic therefore never sees a half-updated or corrupted parameter set.

Parameters:
- SOF, 8'hAA, start-of-frame marker byte.
- N_PAYLOAD, 9, payload byte count (fixed by the field map below).
- TIMEOUT, 50_000_000, max clk cycles between consecutive bytes inside a frame (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- byte_in  in  8  received byte, valid when byte_vld=1
- byte_vld  in  1  one-cycle strobe per received byte, already synchronised to clk
- rx_err  in  1  one-cycle strobe, UART framing/stop-bit error
- humedad  out  12  moisture reading
- melodia1  out  4  watering-alarm melody id
- melodia2  out  4  tank-refill melody id
- maceta  out  4  pot size code
- tipoPlanta  out  4  plant type code
- hora  out  8  hour, binary 0..23
- minutos  out  8  minute, binary 0..59
- luxes  out  20  light level
- frame_ok  out  1  one-cycle pulse, fields updated
- frame_err  out  1  one-cycle pulse, frame discarded
- err_cnt  out  8  saturating count of discarded frames

Behaviour:
- Reset: all field outputs 0, frame_ok=0, frame_err=0, err_cnt=0, FSM in IDLE. Reset mid-frame drops the frame without a frame_err pulse.
- Frame layout is SOF, then P0..P8, then CHK. Field map:
  - humedad = {P0[3:0], P1}
  - melodia1 = P2[7:4], melodia2 = P2[3:0]
  - maceta = P3[7:4], tipoPlanta = P3[3:0]
  - hora = P4, minutos = P5
  - luxes = {P6[3:0], P7, P8}
  - CHK = XOR of P0..P8. Upper nibbles of P0 and P6 are ignored.
- IDLE: byte_vld with byte_in==SOF goes to PAYLOAD, idx=0, running xor=0, gap counter=0. Any other byte is ignored silently, with no error.
- PAYLOAD: each byte_vld writes a shadow register[idx], xors the byte into the running checksum and increments idx. When idx reaches N_PAYLOAD-1, the next state is CHECK. A byte equal to SOF inside the payload is treated as data; there is no resync.
- CHECK: the next byte_vld is CHK. The frame is good when CHK==xor AND hora<=23 AND minutos<=59, giving COMMIT; otherwise ERROR.
- COMMIT (one cycle): shadow copied to all field outputs in one cycle, frame_ok=1, then IDLE. Latency is exactly 1 clk from the CHK strobe to updated outputs and the frame_ok pulse.
- ERROR (one cycle): frame_err=1, err_cnt+1 saturating at 255, outputs keep their previous values, then IDLE.
- Gap counter: in PAYLOAD/CHECK it increments each clk and clears on every byte_vld. Reaching TIMEOUT goes to ERROR.
- rx_err in PAYLOAD/CHECK goes to ERROR next cycle. rx_err in IDLE is ignored. rx_err and byte_vld together: rx_err wins and the byte is discarded.
- The shadow register is never visible on outputs; outputs change only in COMMIT.
- A byte_vld arriving during COMMIT/ERROR is dropped; upstream byte spacing of at least 2 clk is guaranteed by the baud rate.

Decomposition:
- Shared package trama_pkg holds:
  - state encoding (IDLE, PAYLOAD, CHECK, COMMIT, ERROR)
  - SOF
  - N_PAYLOAD
  - payload index constants (IDX_HUM_H..IDX_LUX_L)
  - range limits HORA_MAX=23, MIN_MAX=59
- One sub-module, trama_timeout: loadable gap counter with clear input and expiry flag.
- Everything else is flat in trama_rx.

Test Plan:
1. Good frame:
   - Stimulus: AA 03 E8 21 34 0E 1E 00 C3 50, CHK = XOR of payload.
   - Response: humedad=0x3E8, melodia1=2, melodia2=1, maceta=3, tipoPlanta=4, hora=14, minutos=30, luxes=0x0C350, with frame_ok on the cycle after CHK.
2. Bad checksum:
   - Stimulus: same frame with CHK^0x01.
   - Response: frame_err pulse, err_cnt=1, outputs unchanged from the prior good frame.
3. Range violation:
   - Stimulus: valid checksum with hora=24.
   - Response: frame_err, no output change.
   - Separately, minutos=60 gives the same result.
4. Timeout:
   - Stimulus: AA plus 4 bytes, then idle for TIMEOUT cycles.
   - Response: frame_err exactly at expiry. A following good frame is accepted normally.
5. Noise, SOF inside payload and rx_err:
   - Stimulus: garbage bytes 00 55 FF before AA.
   - Response: ignored, and the frame is still accepted. A payload containing AA is accepted as data.
   - Stimulus: rx_err strobe at P5.
   - Response: frame_err, err_cnt increments.
6. Reset and saturation:
   - Stimulus: rst asserted mid-PAYLOAD.
   - Response: all outputs 0, no frame_err, IDLE.
   - Stimulus: 260 bad frames.
   - Response: err_cnt holds at 255.
